// File: rtl/moore_overlap_1010.sv
// moore_overlap_1010: Moore FSM detecting serial 1010 with overlap; y high while in S4.
module moore_overlap_1010 (
    output logic y,
    input  logic clock,
    input  logic reset,
    input  logic x
);
    typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;
    state_t r_state;
    state_t w_next;
    always_comb begin
        w_next = S0;
        case (r_state)
            S0: w_next = x ? S1 : S0;
            S1: w_next = x ? S1 : S2;
            S2: w_next = x ? S3 : S0;
            S3: w_next = x ? S1 : S4;
            S4: w_next = x ? S3 : S0;
            default: w_next = S0;
        endcase
    end
    // y is registered alongside the state so it always equals (state == S4)
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S0;
            y       <= 1'b0;
        end else begin
            r_state <= w_next;
            y       <= (w_next == S4);
        end
    end
endmodule

// File: tb/tb_moore_overlap_1010.sv
// tb_moore_overlap_1010: scoreboard bench; reference model tracks the last four bits since reset.
module tb_moore_overlap_1010;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic y;
    int checks = 0;
    int failures = 0;
    bit exp_q[$];
    logic [3:0] hist = 4'd0;
    int cnt = 0;

    moore_overlap_1010 dut (.y(y), .clock(clk), .reset(rst_n), .x(x));

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic b);
        rst_n = r;
        x = b;
        @(posedge clk);
        if (!r) begin
            hist = 4'd0;
            cnt = 0;
        end else begin
            hist = {hist[2:0], b};
            cnt = (cnt < 4) ? cnt + 1 : 4;
        end
        exp_q.push_back(cnt >= 4 && hist == 4'b1010);
        #2 x = ~b;
        #4;
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, v[i]);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                failures++;
                $display("FAIL y_check at %0t: y=%b expected=%b", $time, y, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        bits(16'b10101010, 8);
        step(1'b0, 1'b0);
        bits(16'b1011010, 7);
        step(1'b0, 1'b0);
        bits(16'b11001010, 8);
        step(1'b0, 1'b0);
        bits(16'b101, 3);
        step(1'b0, 1'b1);
        bits(16'b010, 3);
        step(1'b0, 1'b0);
        bits(16'b1010, 4);
        step(1'b0, 1'b0);
        bits(16'b1010, 4);
        step(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) step(($urandom_range(0, 39) != 0), 1'($urandom));
        step(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
